simd_mode_dispatch: RTL

- Registered, flow-controlled dispatcher in front of the SIMD array's function units (MAC/DIV/EXP/LOG and future modes).
- Routes each operand beat (LANES x DW A/B pairs) to exactly one unit, selected by a per-beat mode tag.
- Tracks outstanding beats per active mode and drains the active unit before switching modes, so results from different units never interleave.

---
 rtl/simd_pkg.sv | 22 ++
 rtl/inflight_ctr.sv | 34 +++
 rtl/simd_mode_dispatch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared types and constants for the SIMD mode dispatcher
package simd_pkg;

    // Native operand width of the MAC array; default lane width of the dispatcher
    localparam int MAC_BW = 8;

    // Downstream unit encoding carried in the per-beat mode tag
    typedef enum logic [1:0] {
        MODE_MAC = 2'd0,
        MODE_DIV = 2'd1,
        MODE_EXP = 2'd2,
        MODE_LOG = 2'd3
    } mode_e;

    // Dispatcher control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } disp_state_e;

endpackage

// File: rtl/inflight_ctr.sv
// rtl/inflight_ctr.sv - up/down counter of dispatched-but-unfinished beats
module inflight_ctr #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_underflow
);

    logic [W-1:0] r_count;
    logic         w_dec_ok;

    // A decrement against an empty counter is dropped and flagged instead
    assign o_underflow = i_dec && (r_count == '0);
    assign w_dec_ok    = i_dec && !o_underflow;

    // Simultaneous increment and valid decrement cancel out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !w_dec_ok) begin
            r_count <= r_count + W'(1);
        end else if (!i_inc && w_dec_ok) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/simd_mode_dispatch.sv
// rtl/simd_mode_dispatch.sv - routes operand beats to one SIMD unit per mode; optional DISPATCH_STATS_EN adds switch/drain counters
module simd_mode_dispatch
    import simd_pkg::*;
#(
    parameter  int LANES        = 64,
    parameter  int DW           = MAC_BW,
    parameter  int NUM_MODES    = 4,
    parameter  int MAX_INFLIGHT = 16,
    localparam int MODE_W       = $clog2(NUM_MODES),
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MODE_W-1:0]     in_mode,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_b,
    output logic [NUM_MODES-1:0]  out_valid,
    input  logic [NUM_MODES-1:0]  out_ready,
    output logic [LANES*DW-1:0]   out_a,
    output logic [LANES*DW-1:0]   out_b,
    input  logic [NUM_MODES-1:0]  done,
    output logic [MODE_W-1:0]     act_mode,
    output logic                  busy,
    output logic                  err
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]           stat_switch,
    output logic [31:0]           stat_drain_cyc
`endif
);

    disp_state_e           r_state;
    logic [MODE_W-1:0]     r_act_mode;
    logic [NUM_MODES-1:0]  r_out_valid;
    logic [LANES*DW-1:0]   r_out_a;
    logic [LANES*DW-1:0]   r_out_b;
    logic                  r_err;

    logic [NUM_MODES-1:0]  w_act_oh;
    logic [NUM_MODES-1:0]  w_in_oh;
    logic                  w_vld;
    logic                  w_out_hs;
    logic                  w_slot_free;
    logic                  w_credit;
    logic                  w_mode_match;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_done_act;
    logic                  w_done_err;
    logic                  w_underflow;
    logic                  w_drained;
    logic [CNT_W-1:0]      w_inflight;

    assign w_act_oh     = NUM_MODES'(1) << r_act_mode;
    assign w_in_oh      = NUM_MODES'(1) << in_mode;
    assign w_vld        = |r_out_valid;
    assign w_out_hs     = |(r_out_valid & out_ready);
    assign w_slot_free  = !w_vld || out_ready[r_act_mode];
    // The beat sitting in the output register already holds a credit
    assign w_credit     = ({1'b0, w_inflight} + (CNT_W+1)'(w_vld)) < (CNT_W+1)'(MAX_INFLIGHT);
    assign w_mode_match = (in_mode == r_act_mode);
    assign w_drained    = (w_inflight == '0) && !w_vld;
    assign w_accept     = in_valid && w_in_ready;

    // Only completions from the active unit count; anything else is a protocol error
    assign w_done_act   = |(done & w_act_oh);
    assign w_done_err   = (|(done & ~w_act_oh)) || w_underflow;

    inflight_ctr #(
        .MAX (MAX_INFLIGHT),
        .W   (CNT_W)
    ) u_inflight_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_out_hs),
        .i_dec       (w_done_act),
        .o_count     (w_inflight),
        .o_underflow (w_underflow)
    );

    // Input acceptance per state; held low while reset is asserted
    always_comb begin
        w_in_ready = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE:    w_in_ready = w_slot_free;
                RUN:     w_in_ready = w_slot_free && w_credit && w_mode_match;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    // Control FSM with the output register and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_act_mode  <= '0;
            r_out_valid <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_done_err) begin
                r_err <= 1'b1;
            end

            // Bus is zeroed whenever nothing is presented downstream
            if (w_accept) begin
                r_out_valid <= w_in_oh;
                r_out_a     <= in_a;
                r_out_b     <= in_b;
            end else if (w_out_hs) begin
                r_out_valid <= '0;
                r_out_a     <= '0;
                r_out_b     <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_act_mode <= in_mode;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (in_valid && !w_mode_match) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Switch only once the old unit has nothing outstanding
                    if (w_drained) begin
                        if (in_valid) begin
                            r_act_mode <= in_mode;
                            r_state    <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign act_mode  = r_act_mode;
    assign busy      = (w_inflight != '0) || w_vld;
    assign err       = r_err;

`ifdef DISPATCH_STATS_EN
    logic [31:0] r_stat_switch;
    logic [31:0] r_stat_drain_cyc;
    logic        w_switch;

    assign w_switch = (r_state == DRAIN) && w_drained && in_valid;

    // Saturating counters of completed switches and cycles spent draining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_switch    <= '0;
            r_stat_drain_cyc <= '0;
        end else begin
            if (w_switch && (r_stat_switch != '1)) begin
                r_stat_switch <= r_stat_switch + 32'd1;
            end
            if ((r_state == DRAIN) && (r_stat_drain_cyc != '1)) begin
                r_stat_drain_cyc <= r_stat_drain_cyc + 32'd1;
            end
        end
    end

    assign stat_switch    = r_stat_switch;
    assign stat_drain_cyc = r_stat_drain_cyc;
`endif

endmodule
